// File: rtl/raster_addr_gen.sv
// raster_addr_gen: turns the VGA sync generator's enables into one video-memory
// read request per displayed pixel, with integer horizontal/vertical scaling,
// and delays hde/vde/hsync/vsync so they line up with the returning pixel data.
// Optional build macro RASTER_ADDR_GEN_PAGE_FLIP_EN adds page_sel and
// PAGE_OFFSET, selecting between two frame buffers at each frame start.
module raster_addr_gen #(
    parameter int ADDR_W      = 20,
    parameter int BASE_ADDR   = 0,
    parameter int LINE_STRIDE = 640,
    parameter int H_SCALE     = 1,
    parameter int V_SCALE     = 1,
`ifdef RASTER_ADDR_GEN_PAGE_FLIP_EN
    parameter int PAGE_OFFSET = 307200,
`endif
    parameter int PIPE_DELAY  = 2
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [3:0]        pc_ena,
    input  logic              hde,
    input  logic              vde,
    input  logic              hsync,
    input  logic              vsync,
`ifdef RASTER_ADDR_GEN_PAGE_FLIP_EN
    input  logic              page_sel,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ena,
    output logic              hde_out,
    output logic              vde_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    // All parameter arithmetic is folded to ADDR_W bits so adds wrap silently.
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_STRIDE);
    localparam logic [3:0]        H_LAST = 4'(H_SCALE - 1);
    localparam logic [3:0]        V_LAST = 4'(V_SCALE - 1);

    logic [ADDR_W-1:0]           line_base;
    logic [ADDR_W-1:0]           addr;
    logic [ADDR_W-1:0]           frame_base;
    logic [3:0]                  h_rep;
    logic [3:0]                  v_rep;
    logic                        vsync_d;
    logic                        hde_d;
    logic [PIPE_DELAY-1:0][3:0]  dly_pipe;

    logic tick;
    logic fs;
    logic le;
    logic active;

    // Pixel tick is the pc_ena == 0 phase; frame start is a vsync rise,
    // line end is the hde fall inside the vertical display window.
    assign tick   = (pc_ena == 4'd0);
    assign fs     = vsync & ~vsync_d;
    assign le     = ~hde & hde_d & vde;
    assign active = hde & vde;

`ifdef RASTER_ADDR_GEN_PAGE_FLIP_EN
    localparam logic [ADDR_W-1:0] PAGE_OFS = ADDR_W'(PAGE_OFFSET);
    // page_sel only matters at FS, where frame_base is consumed.
    assign frame_base = BASE + (page_sel ? PAGE_OFS : '0);
`else
    assign frame_base = BASE;
`endif

    // Edge-detect history and sync/enable delay line, both advanced per tick.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            vsync_d  <= 1'b0;
            hde_d    <= 1'b0;
            dly_pipe <= '0;
        end else if (tick) begin
            vsync_d     <= vsync;
            hde_d       <= hde;
            dly_pipe[0] <= {hde, vde, hsync, vsync};
            for (int i = 1; i < PIPE_DELAY; i++)
                dly_pipe[i] <= dly_pipe[i-1];
        end
    end

    assign {hde_out, vde_out, hsync_out, vsync_out} = dly_pipe[PIPE_DELAY-1];

    // Address walker: FS reloads the frame base, active ticks issue a read and
    // step addr every H_SCALE ticks, LE either replays or advances the line.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            rd_addr   <= '0;
            rd_ena    <= 1'b0;
            line_base <= BASE;
            addr      <= BASE;
            h_rep     <= '0;
            v_rep     <= '0;
        end else begin
            rd_ena <= 1'b0;
            if (tick) begin
                if (fs) begin
                    line_base <= frame_base;
                    addr      <= frame_base;
                    h_rep     <= '0;
                    v_rep     <= '0;
                end else if (active) begin
                    rd_addr <= addr;
                    rd_ena  <= 1'b1;
                    if (h_rep == H_LAST) begin
                        h_rep <= '0;
                        addr  <= addr + 1'b1;
                    end else begin
                        h_rep <= h_rep + 4'd1;
                    end
                end else if (le) begin
                    h_rep <= '0;
                    if (v_rep == V_LAST) begin
                        v_rep     <= '0;
                        line_base <= line_base + STRIDE;
                        addr      <= line_base + STRIDE;
                    end else begin
                        v_rep <= v_rep + 4'd1;
                        addr  <= line_base;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_raster_addr_gen.sv
// Bench for raster_addr_gen: a reduced 8x4 raster (12 ticks/line, 7 lines/frame)
// drives three instances (unscaled; 2x2 scale with 3-tick delay; 10-bit wrap).
module tb_raster_addr_gen;

    logic       pclk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pc_ena = 4'd0;
    logic       hde = 1'b0, vde = 1'b0, hsync = 1'b0, vsync = 1'b0;
`ifdef RASTER_ADDR_GEN_PAGE_FLIP_EN
    logic       page_sel = 1'b0;
`endif

    logic [19:0] u0_rd_addr, u1_rd_addr;
    logic [9:0]  u2_rd_addr;
    logic        u0_rd_ena, u1_rd_ena, u2_rd_ena;
    logic [3:0]  u0_outs, u1_outs, u2_outs;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt0 = 0, cnt1 = 0, cnt2 = 0;
    bit pipe_chk = 1'b0;
    logic [15:0][3:0] hist = '0;

    logic [31:0] q0[$], q1[$], q2[$];

    // Hand-computed line start addresses per instance.
    int         s0[4] = '{0, 640, 1280, 1920};
    int         s1[4] = '{0, 0, 640, 640};
    logic [9:0] s2[4] = '{10'd1020, 10'd4, 10'd12, 10'd20};

    always #5 pclk = ~pclk;

    raster_addr_gen u0 (
        .pclk(pclk), .reset(reset), .pc_ena(pc_ena),
        .hde(hde), .vde(vde), .hsync(hsync), .vsync(vsync),
`ifdef RASTER_ADDR_GEN_PAGE_FLIP_EN
        .page_sel(page_sel),
`endif
        .rd_addr(u0_rd_addr), .rd_ena(u0_rd_ena),
        .hde_out(u0_outs[3]), .vde_out(u0_outs[2]),
        .hsync_out(u0_outs[1]), .vsync_out(u0_outs[0])
    );

    raster_addr_gen #(.H_SCALE(2), .V_SCALE(2), .PIPE_DELAY(3)) u1 (
        .pclk(pclk), .reset(reset), .pc_ena(pc_ena),
        .hde(hde), .vde(vde), .hsync(hsync), .vsync(vsync),
`ifdef RASTER_ADDR_GEN_PAGE_FLIP_EN
        .page_sel(page_sel),
`endif
        .rd_addr(u1_rd_addr), .rd_ena(u1_rd_ena),
        .hde_out(u1_outs[3]), .vde_out(u1_outs[2]),
        .hsync_out(u1_outs[1]), .vsync_out(u1_outs[0])
    );

    raster_addr_gen #(.ADDR_W(10), .BASE_ADDR(1020), .LINE_STRIDE(8)) u2 (
        .pclk(pclk), .reset(reset), .pc_ena(pc_ena),
        .hde(hde), .vde(vde), .hsync(hsync), .vsync(vsync),
`ifdef RASTER_ADDR_GEN_PAGE_FLIP_EN
        .page_sel(page_sel),
`endif
        .rd_addr(u2_rd_addr), .rd_ena(u2_rd_ena),
        .hde_out(u2_outs[3]), .vde_out(u2_outs[2]),
        .hsync_out(u2_outs[1]), .vsync_out(u2_outs[0])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every read strobe pops one expected address.
    always @(negedge pclk) begin
        logic [31:0] e;
        if (u0_rd_ena) begin
            cnt0++;
            if (q0.size() == 0) chk("u0_unexpected_rd_ena", 32'(u0_rd_ena), 32'd0);
            else begin e = q0.pop_front(); chk("u0_rd_addr", 32'(u0_rd_addr), e); end
        end
        if (u1_rd_ena) begin
            cnt1++;
            if (q1.size() == 0) chk("u1_unexpected_rd_ena", 32'(u1_rd_ena), 32'd0);
            else begin e = q1.pop_front(); chk("u1_rd_addr", 32'(u1_rd_addr), e); end
        end
        if (u2_rd_ena) begin
            cnt2++;
            if (q2.size() == 0) chk("u2_unexpected_rd_ena", 32'(u2_rd_ena), 32'd0);
            else begin e = q2.pop_front(); chk("u2_rd_addr", 32'(u2_rd_addr), e); end
        end
    end

    // Delay-line monitor: 2 ticks = 8 pclk, 3 ticks = 12 pclk behind the inputs.
    always @(negedge pclk) begin
        if (pipe_chk) begin
            chk("u0_delayed_syncs", 32'(u0_outs), 32'(hist[7]));
            chk("u1_delayed_syncs", 32'(u1_outs), 32'(hist[11]));
        end
        hist = {hist[14:0], {hde, vde, hsync, vsync}};
    end

    // One pixel period: three non-tick edges, then the tick edge.
    task automatic px(input logic h, input logic v, input logic hs, input logic vs);
        hde = h; vde = v; hsync = hs; vsync = vs;
        pc_ena = 4'd3; @(posedge pclk); #1;
        pc_ena = 4'd2; @(posedge pclk); #1;
        pc_ena = 4'd1; @(posedge pclk); #1;
        pc_ena = 4'd0; @(posedge pclk); #1;
    endtask

    task automatic push_exp(input int y, input int x);
        logic [9:0] a2;
        q0.push_back(32'(s0[y] + x));
        q1.push_back(32'(s1[y] + x / 2));
        a2 = s2[y] + 10'(x);
        q2.push_back(32'(a2));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_u0_rd_addr"}, 32'(u0_rd_addr), 32'd0);
        chk({tag, "_u0_rd_ena"},  32'(u0_rd_ena),  32'd0);
        chk({tag, "_u0_outs"},    32'(u0_outs),    32'd0);
        chk({tag, "_u1_rd_addr"}, 32'(u1_rd_addr), 32'd0);
        chk({tag, "_u1_outs"},    32'(u1_outs),    32'd0);
        chk({tag, "_u2_rd_addr"}, 32'(u2_rd_addr), 32'd0);
    endtask

    // Pull reset mid-line while a read strobe is up; outputs must drop at once.
    task automatic reset_mid_line();
        chk("pre_reset_u0_rd_ena",  32'(u0_rd_ena),  32'd1);
        chk("pre_reset_u0_rd_addr", 32'(u0_rd_addr), 32'd643);
        pipe_chk = 1'b0;
        reset = 1'b0;
        hde = 1'b0; vde = 1'b0; hsync = 1'b0; vsync = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        q0.delete(); q1.delete(); q2.delete();
        repeat (3) @(posedge pclk);
        #1 reset = 1'b1;
    endtask

    // Frame: vsync line (FS on first tick), back porch, 4 active lines, front porch.
    task automatic run_frame(input bit cut);
        for (int x = 0; x < 12; x++) px(1'b0, 1'b0, 1'b0, 1'b1);
        for (int x = 0; x < 12; x++) px(1'b0, 1'b0, 1'b0, 1'b0);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 12; x++) begin
                if (x < 8) push_exp(y, x);
                px(x < 8, 1'b1, (x == 9 || x == 10), 1'b0);
                if (cut && y == 1 && x == 3) begin
                    reset_mid_line();
                    return;
                end
            end
        end
        for (int x = 0; x < 12; x++) px(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        chk_zero_outputs("reset_state");
        reset = 1'b1;
        pipe_chk = 1'b1;

        run_frame(1'b0);
        run_frame(1'b1);
        // Blank stretch after reset: no strobe may appear without hde&vde.
        for (int x = 0; x < 24; x++) px(1'b0, 1'b0, 1'b0, 1'b0);
        pipe_chk = 1'b1;
        run_frame(1'b0);
        for (int x = 0; x < 4; x++) px(1'b0, 1'b0, 1'b0, 1'b0);
        pipe_chk = 1'b0;

        chk("u0_pending_expected", 32'(q0.size()), 32'd0);
        chk("u1_pending_expected", 32'(q1.size()), 32'd0);
        chk("u2_pending_expected", 32'(q2.size()), 32'd0);
        // Two full frames of 32 reads plus 11 reads before the reset cut.
        chk("u0_rd_ena_count", 32'(cnt0), 32'd75);
        chk("u1_rd_ena_count", 32'(cnt1), 32'd75);
        chk("u2_rd_ena_count", 32'(cnt2), 32'd75);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
